rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 13 +
 rtl/rr_arbiter_decoder.sv | 17 +
 rtl/rr_arbiter.sv | 117 +++++++++++
 tb/tb_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// default parameter values.
package rr_arbiter_pkg;

    localparam int unsigned DEFAULT_N        = 2;
    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_decoder.sv
// N-to-2^N one-hot decoder with enable; output is all-zero when disabled.
module decoderNxM #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        in,
    input  logic                en,
    output logic [(1<<N)-1:0]   out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with single holder, done/drop/timeout release and a
// mandatory idle cycle between grants.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned M        = (1 << N),
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] req,
    input  logic         done,
    output logic [M-1:0] gnt,
    output logic [N-1:0] gnt_idx,
    output logic         gnt_valid
);

    // A zero MAX_HOLD still needs a legal one-bit counter.
    localparam int unsigned    HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [HW-1:0]  HOLD_SAT  = '1;
    localparam logic           TIMEOUT_EN = (MAX_HOLD > 0);

    state_e         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N-1:0]   gnt_idx_q, gnt_idx_d;
    logic           gnt_valid_q, gnt_valid_d;

    logic [N-1:0]   cand;
    logic [N-1:0]   win_idx;
    logic           win_found;
    logic           hold_expired;
    logic           release_now;

    // Upward search from ptr; the N-bit add wraps M-1 back to 0.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            cand = ptr_q + N'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        hold_expired = TIMEOUT_EN && (hold_q == HOLD_LAST);
        release_now  = done || !req[gnt_idx_q] || hold_expired;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    ptr_d       = win_idx + N'(1);
                    hold_d      = '0;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d     = ST_IDLE;
                    hold_d      = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

    decoderNxM #(
        .N(N)
    ) u_decoder (
        .in  (gnt_idx_q),
        .en  (gnt_valid_q),
        .out (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_arbiter;

    localparam int N        = 2;
    localparam int M        = 4;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst;
    logic [M-1:0] req;
    logic         done;
    logic [M-1:0] gnt;
    logic [N-1:0] gnt_idx;
    logic         gnt_valid;

    int errors = 0;
    int checks = 0;

    // Model state: holder index (-1 when nobody holds), search start, and
    // number of cycles the current holder has had the grant.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_tenure = 0;

    rr_arbiter #(
        .N(N),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick_winner(input logic [M-1:0] r, input int start);
        for (int k = 0; k < M; k++) begin
            int c;
            c = (start + k) % M;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One rising edge; the model consumes the same inputs the DUT sees.
    task automatic tick();
        int w;
        @(posedge clk);
        if (rst) begin
            m_holder = -1;
            m_ptr    = 0;
            m_tenure = 0;
        end else if (m_holder < 0) begin
            w = pick_winner(req, m_ptr);
            if (w >= 0) begin
                m_holder = w;
                m_ptr    = (w + 1) % M;
                m_tenure = 1;
            end
        end else if (done || !req[m_holder] || (MAX_HOLD > 0 && m_tenure == MAX_HOLD)) begin
            m_holder = -1;
            m_tenure = 0;
        end else begin
            m_tenure = m_tenure + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: gnt=%b idx=%0d valid=%b expected 0000/0/0", c, gnt, gnt_idx, gnt_valid);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b idx=%0d valid=%b expected 0001/0/1", gnt, gnt_idx, gnt_valid);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL drop_release: gnt=%b valid=%b expected 0000/0", gnt, gnt_valid);
        end
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b idx=%0d valid=%b expected 0100/2/1", gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: gnt=%b idx=%0d valid=%b expected 0000/0/0", gnt, gnt_idx, gnt_valid);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== N'(exp_seq[g]) || gnt !== M'(1 << exp_seq[g])) begin
                errors++;
                $display("FAIL fair_grant%0d: idx=%0d valid=%b gnt=%b expected idx %0d", g, gnt_idx, gnt_valid, gnt, exp_seq[g]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL fair_idle%0d: valid=%b gnt=%b expected 0/0000", g, gnt_valid, gnt);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b0100;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        req = 4'b0011;
        tick();
        checks++;
        if (gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: idx=%0d valid=%b expected 0/1", gnt_idx, gnt_valid);
        end
        done = 1'b1; tick(); done = 1'b0;
        tick();
        checks++;
        if (gnt_idx !== 2'd1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: idx=%0d valid=%b expected 1/1", gnt_idx, gnt_valid);
        end
        done = 1'b1; tick(); done = 1'b0;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        req = 4'b0001; done = 1'b0;
        tick();
        cnt = gnt_valid ? 1 : 0;
        for (int b = 0; b < 20 && gnt_valid; b++) begin
            tick();
            if (gnt_valid) cnt++;
        end
        checks++;
        if (cnt !== MAX_HOLD || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_len: held %0d cycles valid=%b expected %0d then 0", cnt, gnt_valid, MAX_HOLD);
        end
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL timeout_regrant: idx=%0d valid=%b expected 0/1", gnt_idx, gnt_valid);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop: valid=%b expected 0", gnt_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1000;
        tick();
        checks++;
        if (gnt_idx !== 2'd3 || gnt_valid !== 1'b1 || gnt !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_pre: idx=%0d valid=%b gnt=%b expected 3/1/1000", gnt_idx, gnt_valid, gnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: gnt=%b idx=%0d valid=%b expected 0000/0/0", gnt, gnt_idx, gnt_valid);
        end
        tick();
        checks++;
        if (gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_regrant: idx=%0d valid=%b expected 3/1", gnt_idx, gnt_valid);
        end
        req = 4'b0000; tick();
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: valid=%b expected 0", gnt_valid);
        end
        req = 4'b0010;
        tick();
        checks++;
        if (gnt_idx !== 2'd1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_done_after: idx=%0d valid=%b expected 1/1", gnt_idx, gnt_valid);
        end
        req = 4'b0000; tick(); tick();
    endtask

    task automatic test_random();
        logic [M-1:0] exp_gnt;
        int           exp_idx;
        for (int c = 0; c < 400; c++) begin
            req  = M'($urandom_range(0, 15));
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 49) == 0);
            tick();
            exp_idx = (m_holder >= 0) ? m_holder : 0;
            exp_gnt = (m_holder >= 0) ? M'(1 << m_holder) : '0;
            checks++;
            if (gnt_valid !== (m_holder >= 0) || gnt_idx !== N'(exp_idx) || gnt !== exp_gnt) begin
                errors++;
                $display("FAIL random_cyc%0d: gnt=%b idx=%0d valid=%b expected %b/%0d/%b", c, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx, (m_holder >= 0));
            end
        end
        rst = 1'b0; done = 1'b0; req = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
